// File: rtl/txrx_sequencer_if.sv
// Handshake and status bundle between a packet requester and the txrx_sequencer.
interface txrx_sequencer_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] pkt_len;
    logic             stall;
    logic             abort;
    logic             en_stuf;
    logic             en_nrzi;
    logic             en_unstuf;
    logic             en_sipo;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] bit_cnt;
    logic             err;

    modport master (
        output start, pkt_len, stall, abort,
        input  en_stuf, en_nrzi, en_unstuf, en_sipo,
        input  busy, done, bit_cnt, err
    );

    modport slave (
        input  start, pkt_len, stall, abort,
        output en_stuf, en_nrzi, en_unstuf, en_sipo,
        output busy, done, bit_cnt, err
    );
endinterface

// File: rtl/txrx_sequencer.sv
// Stage-enable sequencer for the stuff/NRZI/unstuff/SIPO chain.
// Optional stall timeout enabled by defining SEQ_TIMEOUT_EN.
module txrx_sequencer #(
    parameter int LEN_W     = 8,
    parameter int STALL_MAX = 7
) (
    input  logic           clk,
    input  logic           rst,
    txrx_sequencer_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_RAMP1  = 4'd1,
        S_RAMP2  = 4'd2,
        S_RUN    = 4'd3,
        S_DRAIN1 = 4'd4,
        S_DRAIN2 = 4'd5,
        S_DRAIN3 = 4'd6,
        S_DONE   = 4'd7,
        S_ERR    = 4'd8
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic             accept;
    logic             last_bit;

    assign accept   = (state == S_IDLE) && bus.start && !bus.abort
                   && (bus.pkt_len != '0);
    assign last_bit = (cnt_q == len_q - LEN_W'(1));

`ifdef SEQ_TIMEOUT_EN
    localparam int SC_W = $clog2(STALL_MAX + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(STALL_MAX - 1);

    logic [SC_W-1:0] stall_cnt;
    logic            stall_timeout;

    assign stall_timeout = (stall_cnt == SC_LAST);

    // Counts only consecutive stalled RUN cycles; anything else restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (state == S_RUN && bus.stall && !bus.abort)
            stall_cnt <= stall_cnt + SC_W'(1);
        else
            stall_cnt <= '0;
    end
`else
    localparam int unused_stall_max = STALL_MAX;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_IDLE;
        unique case (state)
            S_IDLE:   state_nxt = accept ? S_RAMP1 : S_IDLE;
            S_RAMP1:  state_nxt = bus.abort ? S_IDLE : S_RAMP2;
            S_RAMP2:  state_nxt = bus.abort ? S_IDLE : S_RUN;
            S_RUN: begin
                if (bus.abort)
                    state_nxt = S_IDLE;
                else if (bus.stall)
`ifdef SEQ_TIMEOUT_EN
                    state_nxt = stall_timeout ? S_ERR : S_RUN;
`else
                    state_nxt = S_RUN;
`endif
                else
                    state_nxt = last_bit ? S_DRAIN1 : S_RUN;
            end
            S_DRAIN1: state_nxt = bus.abort ? S_IDLE : S_DRAIN2;
            S_DRAIN2: state_nxt = bus.abort ? S_IDLE : S_DRAIN3;
            S_DRAIN3: state_nxt = bus.abort ? S_IDLE : S_DONE;
            S_DONE:   state_nxt = S_IDLE;
`ifdef SEQ_TIMEOUT_EN
            S_ERR:    state_nxt = bus.abort ? S_IDLE : S_ERR;
`else
            S_ERR:    state_nxt = S_IDLE;
`endif
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            len_q <= bus.pkt_len;
            cnt_q <= '0;
        end else if (state == S_RUN && !bus.abort && !bus.stall) begin
            cnt_q <= cnt_q + LEN_W'(1);
        end
    end

    // Outputs depend on the state register only, never on inputs.
    always_comb begin
        bus.en_stuf   = 1'b0;
        bus.en_nrzi   = 1'b0;
        bus.en_unstuf = 1'b0;
        bus.en_sipo   = 1'b0;
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        bus.busy      = (state != S_IDLE);
        bus.bit_cnt   = cnt_q;
        unique case (state)
            S_RAMP1: begin
                bus.en_stuf = 1'b1;
            end
            S_RAMP2: begin
                bus.en_stuf = 1'b1;
                bus.en_nrzi = 1'b1;
            end
            S_RUN: begin
                bus.en_stuf   = 1'b1;
                bus.en_nrzi   = 1'b1;
                bus.en_unstuf = 1'b1;
                bus.en_sipo   = 1'b1;
            end
            S_DRAIN1: begin
                bus.en_nrzi   = 1'b1;
                bus.en_unstuf = 1'b1;
                bus.en_sipo   = 1'b1;
            end
            S_DRAIN2: begin
                bus.en_unstuf = 1'b1;
                bus.en_sipo   = 1'b1;
            end
            S_DRAIN3: begin
                bus.en_sipo = 1'b1;
            end
            S_DONE: begin
                bus.done = 1'b1;
            end
            S_ERR: begin
`ifdef SEQ_TIMEOUT_EN
                bus.err = 1'b1;
`else
                bus.err = 1'b0;
`endif
            end
            default: begin
                bus.busy = (state != S_IDLE);
            end
        endcase
    end

endmodule

// File: tb/tb_txrx_sequencer.sv
// Directed self-checking bench for txrx_sequencer.
// Expectations for the stall timeout follow SEQ_TIMEOUT_EN.
module tb_txrx_sequencer;

    localparam int LEN_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    txrx_sequencer_if #(.LEN_W(LEN_W)) bus ();

    txrx_sequencer #(.LEN_W(LEN_W), .STALL_MAX(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] en4();
        return {bus.en_sipo, bus.en_unstuf, bus.en_nrzi, bus.en_stuf};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] en_exp,
                       input logic busy_exp, input logic done_exp,
                       input logic [7:0] cnt_exp);
        n_chk++;
        if (en4() !== en_exp || bus.busy !== busy_exp ||
            bus.done !== done_exp || bus.bit_cnt !== cnt_exp) begin
            n_fail++;
            $display("FAIL %s: en=%b busy=%b done=%b cnt=%0d, want en=%b busy=%b done=%b cnt=%0d",
                     nm, en4(), bus.busy, bus.done, bus.bit_cnt,
                     en_exp, busy_exp, done_exp, cnt_exp);
        end
    endtask

    task automatic begin_pkt(input logic [7:0] len);
        bus.start   = 1'b1;
        bus.pkt_len = len;
        tick();
        bus.start   = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 0; bus.pkt_len = 0; bus.stall = 0; bus.abort = 0;
        rst = 1'b1;
        #2;
        chk("reset_async", 4'b0000, 0, 0, 8'd0);
        n_chk++;
        if (bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: err=%b want 0", bus.err);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("reset_idle", 4'b0000, 0, 0, 8'd0);
    endtask

    task automatic test_basic();
        begin_pkt(8'd4);
        chk("b_e0", 4'b0001, 1, 0, 8'd0);
        tick(); chk("b_e1", 4'b0011, 1, 0, 8'd0);
        tick(); chk("b_e2", 4'b1111, 1, 0, 8'd0);
        tick(); chk("b_e3", 4'b1111, 1, 0, 8'd1);
        tick(); chk("b_e4", 4'b1111, 1, 0, 8'd2);
        tick(); chk("b_e5", 4'b1111, 1, 0, 8'd3);
        tick(); chk("b_e6", 4'b1110, 1, 0, 8'd4);
        tick(); chk("b_e7", 4'b1100, 1, 0, 8'd4);
        tick(); chk("b_e8", 4'b1000, 1, 0, 8'd4);
        tick(); chk("b_e9", 4'b0000, 1, 1, 8'd4);
        tick(); chk("b_e10", 4'b0000, 0, 0, 8'd4);
        tick(); chk("b_e11", 4'b0000, 0, 0, 8'd4);
    endtask

    task automatic test_stall();
        begin_pkt(8'd4);
        tick();
        tick();
        tick(); chk("s_e3", 4'b1111, 1, 0, 8'd1);
        bus.stall = 1'b1;
        tick(); chk("s_e4", 4'b1111, 1, 0, 8'd1);
        tick(); chk("s_e5", 4'b1111, 1, 0, 8'd1);
        bus.stall = 1'b0;
        tick(); chk("s_e6", 4'b1111, 1, 0, 8'd2);
        tick(); chk("s_e7", 4'b1111, 1, 0, 8'd3);
        tick(); chk("s_e8", 4'b1110, 1, 0, 8'd4);
        bus.stall = 1'b1;
        tick(); chk("s_e9", 4'b1100, 1, 0, 8'd4);
        tick(); chk("s_e10", 4'b1000, 1, 0, 8'd4);
        bus.stall = 1'b0;
        tick(); chk("s_e11", 4'b0000, 1, 1, 8'd4);
        tick(); chk("s_e12", 4'b0000, 0, 0, 8'd4);
    endtask

    task automatic test_abort();
        begin_pkt(8'd4);
        repeat (7) tick();
        chk("a_drain2", 4'b1100, 1, 0, 8'd4);
        bus.abort = 1'b1;
        tick(); chk("a_idle", 4'b0000, 0, 0, 8'd4);
        bus.abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("a_nodone", 4'b0000, 0, 0, 8'd4);
        end
    endtask

    task automatic test_ignore();
        begin_pkt(8'd0);
        chk("i_len0", 4'b0000, 0, 0, 8'd4);
        bus.abort = 1'b1;
        begin_pkt(8'd3);
        bus.abort = 1'b0;
        chk("i_abort", 4'b0000, 0, 0, 8'd4);
        begin_pkt(8'd4);
        tick();
        tick();
        tick(); chk("i_run_e3", 4'b1111, 1, 0, 8'd1);
        bus.start   = 1'b1;
        bus.pkt_len = 8'd2;
        tick(); chk("i_run_e4", 4'b1111, 1, 0, 8'd2);
        bus.start   = 1'b0;
        tick(); chk("i_run_e5", 4'b1111, 1, 0, 8'd3);
        tick(); chk("i_run_e6", 4'b1110, 1, 0, 8'd4);
        repeat (3) tick();
        chk("i_done", 4'b0000, 1, 1, 8'd4);
        tick();
    endtask

    task automatic test_timeout();
        begin_pkt(8'd4);
        tick();
        tick(); chk("t_run", 4'b1111, 1, 0, 8'd0);
        bus.stall = 1'b1;
        repeat (6) tick();
        chk("t_6stall", 4'b1111, 1, 0, 8'd0);
        tick();
`ifdef SEQ_TIMEOUT_EN
        chk("t_err", 4'b0000, 1, 0, 8'd0);
        n_chk++;
        if (bus.err !== 1'b1) begin
            n_fail++;
            $display("FAIL t_err_flag: err=%b want 1", bus.err);
        end
        tick();
        bus.stall = 1'b0;
        tick(); chk("t_err_hold", 4'b0000, 1, 0, 8'd0);
`else
        chk("t_noerr", 4'b1111, 1, 0, 8'd0);
        n_chk++;
        if (bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL t_err_flag: err=%b want 0", bus.err);
        end
        repeat (10) tick();
        chk("t_run_hold", 4'b1111, 1, 0, 8'd0);
        bus.stall = 1'b0;
`endif
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("t_abort", 4'b0000, 0, 0, 8'd0);
        n_chk++;
        if (bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL t_abort_err: err=%b want 0", bus.err);
        end
    endtask

    task automatic test_async_reset();
        begin_pkt(8'd5);
        repeat (3) tick();
        chk("r_run", 4'b1111, 1, 0, 8'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("r_async", 4'b0000, 0, 0, 8'd0);
        #1;
        rst = 1'b0;
        tick(); chk("r_after", 4'b0000, 0, 0, 8'd0);
        tick(); chk("r_nodone", 4'b0000, 0, 0, 8'd0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_abort();
        test_ignore();
        test_timeout();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
